wash_phase_timer: RTL

- Sensor/timer front-end sitting directly upstream of the washing-machine controller FSM.
- Converts raw water-level samples into the debounced `filled`/`drained` levels.
- Watches the controller's actuator outputs (`motor_on`, `drain_value_on`, `soap_wash`, `water_wash`) and generates `cycle_timeout` and `spin_timeout` as held levels.
- Those four outputs wire straight to the same-named controller inputs.

---
 rtl/wash_phase_timer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wash_phase_timer.sv
// Water-level debounce and wash/rinse/spin phase timer.
// Sits upstream of the washer controller and feeds its sensor inputs.
module wash_phase_timer #(
  parameter int unsigned      LVL_W     = 8,
  parameter logic [LVL_W-1:0] FULL_LVL  = LVL_W'(200),
  parameter logic [LVL_W-1:0] EMPTY_LVL = LVL_W'(10),
  parameter int unsigned      DEB_CYC   = 4,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] WASH_CYC  = CNT_W'(1000),
  parameter logic [CNT_W-1:0] RINSE_CYC = CNT_W'(600),
  parameter logic [CNT_W-1:0] SPIN_CYC  = CNT_W'(400)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LVL_W-1:0] level_raw,
  input  logic             motor_on,
  input  logic             drain_value_on,
  input  logic             soap_wash,
  input  logic             water_wash,
  output logic             filled,
  output logic             drained,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_M1  = DEB_W'(DEB_CYC - 1);

  // A zero limit would never match, so it behaves as one clock
  localparam logic [CNT_W-1:0] WASH_LIM  =
    (WASH_CYC == '0) ? CNT_W'(1) : WASH_CYC;
  localparam logic [CNT_W-1:0] RINSE_LIM =
    (RINSE_CYC == '0) ? CNT_W'(1) : RINSE_CYC;
  localparam logic [CNT_W-1:0] SPIN_LIM  =
    (SPIN_CYC == '0) ? CNT_W'(1) : SPIN_CYC;

  typedef enum logic [2:0] {
    S_IDLE, S_WASH, S_RINSE, S_SPIN, S_EXP
  } state_e;

  typedef enum logic [1:0] {
    PH_NONE, PH_WASH, PH_RINSE, PH_SPIN
  } phase_e;

  logic             full_c, empty_c;
  logic [DEB_W-1:0] fcnt_q, fcnt_d;
  logic [DEB_W-1:0] ecnt_q, ecnt_d;
  logic             filled_q, filled_d;
  logic             drained_q, drained_d;

  state_e           state_q, state_d, req_st;
  phase_e           exp_ph_q, exp_ph_d;
  phase_e           req, cur_ph;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim, lim_m1;
  logic             cto_q, cto_d;
  logic             sto_q, sto_d;

  assign full_c  = (level_raw >= FULL_LVL);
  assign empty_c = (level_raw <= EMPTY_LVL);

  always_comb begin
    fcnt_d = '0;
    ecnt_d = '0;
    if (full_c)
      fcnt_d = (fcnt_q == DEB_MAX) ? DEB_MAX
             : fcnt_q + DEB_W'(1);
    if (empty_c)
      ecnt_d = (ecnt_q == DEB_MAX) ? DEB_MAX
             : ecnt_q + DEB_W'(1);
    filled_d  = full_c && (fcnt_q >= DEB_M1);
    // filled wins if the thresholds overlap
    drained_d = empty_c && (ecnt_q >= DEB_M1)
             && !filled_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_q    <= '0;
      ecnt_q    <= '0;
      filled_q  <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
      filled_q  <= filled_d;
      drained_q <= drained_d;
    end
  end

  always_comb begin
    req = PH_NONE;
    unique case (1'b1)
      motor_on & drain_value_on:
        req = PH_SPIN;
      motor_on & !drain_value_on & soap_wash:
        req = PH_WASH;
      motor_on & !drain_value_on & !soap_wash
        & water_wash:
        req = PH_RINSE;
      default:
        req = PH_NONE;
    endcase
  end

  always_comb begin
    unique case (req)
      PH_WASH:  req_st = S_WASH;
      PH_RINSE: req_st = S_RINSE;
      PH_SPIN:  req_st = S_SPIN;
      default:  req_st = S_IDLE;
    endcase
    unique case (state_q)
      S_WASH:  cur_ph = PH_WASH;
      S_RINSE: cur_ph = PH_RINSE;
      S_SPIN:  cur_ph = PH_SPIN;
      S_EXP:   cur_ph = exp_ph_q;
      default: cur_ph = PH_NONE;
    endcase
    unique case (cur_ph)
      PH_WASH:  lim = WASH_LIM;
      PH_RINSE: lim = RINSE_LIM;
      PH_SPIN:  lim = SPIN_LIM;
      default:  lim = CNT_W'(1);
    endcase
    lim_m1 = lim - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      exp_ph_q <= PH_NONE;
      cnt_q    <= '0;
      cto_q    <= 1'b0;
      sto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_ph_q <= exp_ph_d;
      cnt_q    <= cnt_d;
      cto_q    <= cto_d;
      sto_q    <= sto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        state_d = req_st;
      S_EXP:
        if (req != cur_ph) state_d = req_st;
      default:
        if (req != cur_ph)
          state_d = req_st;
        else if (cnt_q == lim_m1)
          state_d = S_EXP;
    endcase
  end

  always_comb begin
    cnt_d    = '0;
    cto_d    = 1'b0;
    sto_d    = 1'b0;
    exp_ph_d = exp_ph_q;
    if (state_d == S_EXP) begin
      cnt_d    = cnt_q;
      exp_ph_d = cur_ph;
      cto_d    = (cur_ph == PH_WASH)
              || (cur_ph == PH_RINSE);
      sto_d    = (cur_ph == PH_SPIN);
    end else if (state_d != S_IDLE
              && state_d == state_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign filled        = filled_q;
  assign drained       = drained_q;
  assign cycle_timeout = cto_q;
  assign spin_timeout  = sto_q;
  assign phase_cnt     = cnt_q;

endmodule
